// File: rtl/ex_muldiv.sv
// Iterative M-extension unit for the EX stage: 32-cycle radix-2 multiply and
// restoring divide, with early completion for divide-by-zero and signed overflow.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [31:0] result_o,
  output logic        done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [63:0] mul_acc, div_acc, prod;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo, rem;

  // Operand conditioning for a new instruction.
  always_comb begin
    a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) || (funct3_i[2] && !funct3_i[0]);
    b_signed = (funct3_i == 3'b001) || (funct3_i[2] && !funct3_i[0]);
    a_neg    = a_signed && a_i[31];
    b_neg    = b_signed && b_i[31];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    div_zero = funct3_i[2] && (b_i == 32'd0);
    div_ovf  = funct3_i[2] && !funct3_i[0] && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  end

  // One iteration step; acc holds {remainder, quotient} while dividing.
  always_comb begin
    mul_acc = acc_q + (opb_q[0] ? opa_q : 64'd0);
    rem_sh  = acc_q[63:31];
    diff    = rem_sh - {1'b0, opb_q};
    div_acc = diff[32] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    prod    = neg_q ? -mul_acc : mul_acc;
    quo     = neg_q ? -div_acc[31:0] : div_acc[31:0];
    rem     = neg_rem_q ? -div_acc[63:32] : div_acc[63:32];
  end

  always_comb begin
    // NOTE: every *_d defaults to its flop so no path through this block infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    result_d  = result_q;
    if (rdy) begin
      if (flush_i) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            op_d      = funct3_i[1:0];
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = 5'd0;
            opa_d     = {32'd0, a_mag};
            opb_d     = b_mag;
            acc_d     = funct3_i[2] ? {32'd0, a_mag} : 64'd0;
            if (div_zero) begin
              result_d = funct3_i[1] ? a_i : 32'hFFFF_FFFF;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = funct3_i[1] ? 32'd0 : 32'h8000_0000;
              state_d  = S_DONE;
            end else begin
              state_d = funct3_i[2] ? S_DIV : S_MUL;
            end
          end
          S_MUL: begin
            acc_d = mul_acc;
            opa_d = {opa_q[62:0], 1'b0};
            opb_d = {1'b0, opb_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_d  = S_DONE;
              result_d = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
            end
          end
          S_DIV: begin
            acc_d = div_acc;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_d  = S_DONE;
              result_d = op_q[1] ? rem : quo;
            end
          end
          default: if (!hold_i) state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opa_q     <= 64'd0;
      opb_q     <= 32'd0;
      acc_q     <= 64'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign done_o     = (state_q == S_DONE) && !flush_i;
  assign result_o   = done_o ? result_q : 32'd0;
  assign stallreq_o = !flush_i && (((state_q == S_IDLE) && start_i) ||
                                   (state_q == S_MUL) || (state_q == S_DIV));

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus queues expected results, a negedge
// monitor pops and compares on each new done_o.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, rdy, start_i, hold_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i, b_i;
  logic        stallreq_o, done_o;
  logic [31:0] result_o;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done_seen = 1'b0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .start_i   (start_i),
    .funct3_i  (funct3_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .hold_i    (hold_i),
    .flush_i   (flush_i),
    .stallreq_o(stallreq_o),
    .result_o  (result_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done_o === 1'b1 && !done_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.name, result_o, e.val);
      end
    end
    done_seen = (done_o === 1'b1);
  end

  task automatic expect_result(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int rdy_at);
    int n;
    int st;
    funct3_i = f3;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    expect_result(name, exp);
    #1;
    st = int'(stallreq_o);
    n  = 0;
    while (done_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start_i = 1'b0;
      if (n == rdy_at) rdy = 1'b0;
      if (n == rdy_at + 5) rdy = 1'b1;
      if (n == 2) check({name, "_busy_result"}, result_o, 32'd0);
      if (done_o !== 1'b1) st += int'(stallreq_o);
    end
    start_i = 1'b0;
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_stall_cycles"}, 32'(st), 32'(lat));
    check({name, "_stall_in_done"}, {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst = 1'b1; rdy = 1'b1; start_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'b000; a_i = 32'd0; b_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_stall", {31'd0, stallreq_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mulh_m1_m1",   F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, -1);
    run_op("mulhu_m1_m1",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, -1);
    run_op("mul_m1_m1",    F_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, -1);
    run_op("mulhsu_m1",    F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1);
    run_op("mulh_min_min", F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, -1);
    run_op("div_m7_2",     F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, -1);
    run_op("rem_m7_2",     F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, -1);
    run_op("rem_7_m2",     F_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33, -1);
    run_op("remu_100_7",   F_REMU,   32'd100,       32'd7,         32'd2,         33, -1);
    run_op("divu_5_0",     F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  -1);
    run_op("remu_5_0",     F_REMU,   32'd5,         32'd0,         32'd5,         1,  -1);
    run_op("div_m7_0",     F_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  -1);
    run_op("rem_m7_0",     F_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,  -1);
    run_op("div_ovf",      F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  -1);
    run_op("rem_ovf",      F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  -1);
    run_op("divu_no_ovf",  F_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, -1);
    run_op("div_rdy_gap",  F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 38, 10);

    // Flush in MUL at counter 10, then a fresh start two cycles later.
    funct3_i = F_MUL; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    #1;
    check("flush_cycle_stall", {31'd0, stallreq_o}, 32'd0);
    check("flush_cycle_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_next_stall", {31'd0, stallreq_o}, 32'd0);
    check("flush_next_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    run_op("mul_after_flush", F_MUL, 32'h1234_5678, 32'd10, 32'hB60B_60B0, 33, -1);

    // Hold in DONE with start_i still asserted.
    funct3_i = F_DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    expect_result("divu_hold", 32'd14);
    dn = 0;
    while (done_o !== 1'b1 && dn < 200) begin @(posedge clk); #1; dn++; end
    check("hold_latency", 32'(dn), 32'd33);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_done", {31'd0, done_o}, 32'd1);
      check("hold_result", result_o, 32'd14);
      check("hold_stall", {31'd0, stallreq_o}, 32'd0);
    end
    hold_i  = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    check("hold_release_done", {31'd0, done_o}, 32'd0);
    check("hold_release_stall", {31'd0, stallreq_o}, 32'd0);

    // Reset in the middle of a multiply.
    funct3_i = F_MULHU; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_stall", {31'd0, stallreq_o}, 32'd0);
    check("rst_mid_done", {31'd0, done_o}, 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    dn = 0;
    repeat (40) begin @(posedge clk); #1; dn += int'(done_o); end
    check("rst_no_done", 32'(dn), 32'd0);
    run_op("mul_after_rst", F_MUL, 32'd7, 32'd6, 32'd42, 33, -1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global ready; when low, all internal state holds.
REQ-004 start_i  in  1  EX holds a valid M-extension instruction from the ID/EX register.
REQ-005 funct3_i  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a_i, b_i  in  32 each  rs1 and rs2 operands.
REQ-007 hold_i  in  1  a downstream stage is stalled, so the EX result is not consumed this cycle.
REQ-008 flush_i  in  1  branch taken in EX; abort the current operation.
REQ-009 stallreq_o  out  1  stall request to the stall controller; freezes IF through ID/EX.
REQ-010 result_o  out  32  operation result; valid only when done_o=1.
REQ-011 done_o  out  1  result valid this cycle.

Function
REQ-012 FSM states are IDLE, MUL, DIV and DONE; the iteration counter is 5 bits.
REQ-013 In IDLE with start_i=1, operands and funct3 are latched.
- Next state is MUL for funct3[2]=0, DIV for funct3[2]=1.
- The counter loads 0.
REQ-014 Signed operands are converted to magnitudes and the result sign is recorded.
- MULH: both operands signed. MULHSU: a signed, b unsigned. DIV/REM: both signed.
- All other operations are unsigned.
REQ-015 MUL state runs a radix-2 shift-add over 32 cycles into a 64-bit accumulator.
- After counter=31, the state goes to DONE.
REQ-016 DIV state runs a restoring shift-subtract, one quotient bit per cycle, 32 cycles.
- After counter=31, the state goes to DONE.
REQ-017 Results are formed at the transition into DONE, with sign correction applied to the 64-bit product or to the quotient/remainder.
- MUL returns the low 32 bits of the product; MULH, MULHSU and MULHU return the high 32 bits.
- Remainder sign equals dividend sign.
REQ-018 Divide by zero skips the iterations and goes directly IDLE->DONE.
- Quotient = 0xFFFFFFFF; remainder = a_i.
REQ-019 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) goes directly IDLE->DONE.
- Quotient = 0x80000000; remainder = 0.
REQ-020 Latency:
- Normal operation: start seen in IDLE at cycle T, done_o=1 at cycle T+33.
- Special cases (REQ-018, REQ-019): done_o=1 at cycle T+1.
REQ-021 stallreq_o is combinational: (state==IDLE & start_i & ~flush_i) | state==MUL | state==DIV.
- It is low in DONE, so the pipeline advances at the end of the DONE cycle.
REQ-022 DONE asserts done_o=1 and drives result_o.
- It stays in DONE while hold_i=1; otherwise the next state is IDLE.
- start_i is ignored in DONE, so the held instruction is never re-executed.
REQ-023 flush_i=1 in any state forces the next state to IDLE.
- stallreq_o and done_o are low that cycle, and no new start is accepted that cycle.
REQ-024 When rdy=0, the state, counter, accumulators and outputs hold their values.
- stallreq_o still reflects the current state.
REQ-025 In IDLE, MUL and DIV, result_o=0 and done_o=0.

Reset
REQ-026 When rst=1 at a clock edge, the block forces IDLE, counter=0, accumulators=0, result register=0, and stallreq_o=0, done_o=0, result_o=0.
- rst overrides rdy and flush_i.
REQ-027 rst asserted mid-operation discards the operation with no result produced.

Verification
REQ-028 MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> stallreq_o high 33 cycles, then done_o with result_o=0x00000000.
- The same operands with MULHU -> 0xFFFFFFFE; with MUL -> 0x00000001.
REQ-029 DIV a=-7 (0xFFFFFFF9), b=2 -> result_o=0xFFFFFFFD (-3).
- REM with the same operands -> 0xFFFFFFFF (-1).
REQ-030 DIVU a=5, b=0 -> done_o at T+1 with result_o=0xFFFFFFFF; REMU with the same operands -> 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+1.
REQ-031 flush_i pulsed in MUL at counter=10 -> IDLE next cycle, stallreq_o=0, done_o never asserted.
- A new start two cycles later completes correctly.
REQ-032 hold_i=1 for 3 cycles during DONE -> done_o and result_o stable for 4 cycles, with no restart while start_i stays high.
REQ-033 rdy=0 for 5 cycles mid-DIV -> done_o is delayed by exactly 5 cycles and the result is unchanged.
- rst mid-MUL -> all outputs 0 next cycle.
